// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signal bundle for mem_arbiter.
// slave = the arbiter itself; master = the core/RAM environment around it.
interface mem_arbiter_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 11
);
  // Handshake: a requester raises req with addr (and wren/wdata) and holds them
  // until ready=1 in the same cycle; that cycle is the accept. The matching
  // valid pulses for exactly one cycle on the following cycle, with no stall.
  logic                 if_req;
  logic [WIDTH-1:0]     if_addr;
  logic                 if_ready;
  logic                 if_valid;
  logic [WIDTH-1:0]     if_rdata;

  logic                 d_req;
  logic                 d_wren;
  logic [WIDTH-1:0]     d_addr;
  logic [WIDTH-1:0]     d_wdata;
  logic                 d_ready;
  logic                 d_valid;
  logic [WIDTH-1:0]     d_rdata;

  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_wren;
  logic [WIDTH-1:0]     mem_wdata;
  logic [WIDTH-1:0]     mem_q;

  modport slave (
    input  if_req, if_addr, d_req, d_wren, d_addr, d_wdata, mem_q,
    output if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata,
           mem_addr, mem_wren, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_wren, d_addr, d_wdata, mem_q,
    input  if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata,
           mem_addr, mem_wren, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one registered-address RAM between instruction
// fetch and load/store, with one-cycle response routing and a flash lockout.
module mem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flash_en,
  mem_arbiter_if.slave bus,
  output logic       busy,
  output logic [1:0] state_dbg,
  output logic       rr_last_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_RD = 2'd2,
    RESP_WR = 2'd3
  } state_t;

  typedef enum logic {
    SIDE_IF = 1'b0,
    SIDE_D  = 1'b1
  } side_t;

  state_t               state;
  state_t               state_nxt;
  side_t                rr_last;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] if_word;
  logic [ADDR_BITS-1:0] d_word;
  logic                 contested;
  logic                 grant_if;
  logic                 grant_d;

  // Byte lanes and high address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.if_addr[WIDTH-1:ADDR_BITS+2],
                              bus.d_addr[1:0],  bus.d_addr[WIDTH-1:ADDR_BITS+2]};

  always_comb begin
    if_word   = bus.if_addr[ADDR_BITS+1:2];
    d_word    = bus.d_addr[ADDR_BITS+1:2];
    contested = bus.if_req && bus.d_req;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    if (!rst && !flash_en) begin
      if (contested) begin
        grant_if = (rr_last == SIDE_D);
        grant_d  = (rr_last == SIDE_IF);
      end else begin
        grant_if = bus.if_req;
        grant_d  = bus.d_req;
      end
    end
  end

  // The state names the response owed on the next cycle, chosen by this grant.
  always_comb begin
    state_nxt = IDLE;
    if (grant_if)     state_nxt = RESP_IF;
    else if (grant_d) state_nxt = bus.d_wren ? RESP_WR : RESP_RD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= SIDE_D;
      addr_q  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_if)     addr_q <= if_word;
      else if (grant_d) addr_q <= d_word;
      // Fairness history only moves when both sides actually competed.
      if (contested && grant_if)     rr_last <= SIDE_IF;
      else if (contested && grant_d) rr_last <= SIDE_D;
    end
  end

  always_comb begin
    bus.if_ready  = grant_if;
    bus.d_ready   = grant_d;
    bus.mem_wren  = grant_d && bus.d_wren;
    bus.mem_wdata = (grant_d && bus.d_wren) ? bus.d_wdata : '0;
    bus.mem_addr  = addr_q;
    if (rst)           bus.mem_addr = '0;
    else if (grant_if) bus.mem_addr = if_word;
    else if (grant_d)  bus.mem_addr = d_word;
  end

  // Reset suppresses a response that was already owed.
  always_comb begin
    bus.if_valid = !rst && (state == RESP_IF);
    bus.if_rdata = bus.if_valid ? bus.mem_q : '0;
    bus.d_valid  = !rst && ((state == RESP_RD) || (state == RESP_WR));
    bus.d_rdata  = (!rst && (state == RESP_RD)) ? bus.mem_q : '0;
    busy         = !rst && (state != IDLE);
    state_dbg    = state;
    rr_last_dbg  = rr_last;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, response scoreboard and scenario tasks.
module tb_mem_arbiter;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 11;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flash_en = 1'b0;
  logic       busy;
  logic [1:0] state_dbg;
  logic       rr_last_dbg;

  mem_arbiter_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

  mem_arbiter #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst), .flash_en(flash_en), .bus(bus),
    .busy(busy), .state_dbg(state_dbg), .rr_last_dbg(rr_last_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [WIDTH-1:0] ram [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];

  function automatic logic [WIDTH-1:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [ADDR_BITS-1:0] word_of(input logic [WIDTH-1:0] a);
    return a[ADDR_BITS+1:2];
  endfunction

  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_q <= ram[bus.mem_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_if_q[$];
  logic [WIDTH-1:0] exp_d_q[$];

  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    n_checks++;
    if (bus.if_valid) begin
      if (exp_if_q.size() == 0) begin
        n_fail++; $display("FAIL sb_if_unexpected: if_valid=1 with no expected response");
      end else begin
        e = exp_if_q.pop_front();
        if (bus.if_rdata !== e) begin
          n_fail++; $display("FAIL sb_if_rdata: got %h expected %h", bus.if_rdata, e);
        end
      end
    end else if (bus.if_rdata !== '0) begin
      n_fail++; $display("FAIL sb_if_rdata_idle: got %h expected 0", bus.if_rdata);
    end
    n_checks++;
    if (bus.d_valid) begin
      if (exp_d_q.size() == 0) begin
        n_fail++; $display("FAIL sb_d_unexpected: d_valid=1 with no expected response");
      end else begin
        e = exp_d_q.pop_front();
        if (bus.d_rdata !== e) begin
          n_fail++; $display("FAIL sb_d_rdata: got %h expected %h", bus.d_rdata, e);
        end
      end
    end else if (bus.d_rdata !== '0) begin
      n_fail++; $display("FAIL sb_d_rdata_idle: got %h expected 0", bus.d_rdata);
    end
    if (bus.if_ready) exp_if_q.push_back(ref_mem[word_of(bus.if_addr)]);
    if (bus.d_ready) begin
      if (bus.d_wren) begin
        exp_d_q.push_back('0);
        ref_mem[word_of(bus.d_addr)] = bus.d_wdata;
      end else begin
        exp_d_q.push_back(ref_mem[word_of(bus.d_addr)]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_wren = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    step(); idle_inputs(); flash_en = 1'b0; rst = 1'b1;
    step(); step(); rst = 1'b0;
    exp_if_q.delete(); exp_d_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h10; bus.d_req = 1'b1; bus.d_addr = 32'h24;
    bus.d_wren = 1'b1; bus.d_wdata = 32'h1111_2222;
    step(); step();
    @(negedge clk);
    n_checks++; if (bus.if_ready !== 1'b0 || bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got if=%b d=%b expected 0 0", bus.if_ready, bus.d_ready); end
    n_checks++; if (bus.mem_wren !== 1'b0 || bus.mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem: got wren=%b addr=%h expected 0 0", bus.mem_wren, bus.mem_addr); end
    n_checks++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got if=%b d=%b busy=%b expected 0 0 0", bus.if_valid, bus.d_valid, busy); end
    n_checks++; if (state_dbg !== 2'd0 || rr_last_dbg !== 1'b1) begin n_fail++; $display("FAIL rst_state: got state=%0d rr=%b expected 0 1", state_dbg, rr_last_dbg); end
    step(); idle_inputs(); rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_release: got busy=%b state=%0d expected 0 0", busy, state_dbg); end
  endtask

  task automatic test_fetch();
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h10;
    @(negedge clk);
    n_checks++; if (bus.if_ready !== 1'b1 || bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_ready: got if=%b d=%b expected 1 0", bus.if_ready, bus.d_ready); end
    n_checks++; if (bus.mem_addr !== 11'd4 || bus.mem_wren !== 1'b0) begin n_fail++; $display("FAIL fetch_mem: got addr=%0d wren=%b expected 4 0", bus.mem_addr, bus.mem_wren); end
    step(); bus.if_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== init_word(4)) begin n_fail++; $display("FAIL fetch_resp: got valid=%b data=%h expected 1 %h", bus.if_valid, bus.if_rdata, init_word(4)); end
    n_checks++; if (busy !== 1'b1 || state_dbg !== 2'd1) begin n_fail++; $display("FAIL fetch_busy: got busy=%b state=%0d expected 1 1", busy, state_dbg); end
    step();
    @(negedge clk);
    n_checks++; if (bus.if_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: got valid=%b busy=%b expected 0 0", bus.if_valid, busy); end
  endtask

  task automatic test_contention();
    logic prev_if;
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.d_req = 1'b1; bus.d_wren = 1'b0; bus.d_addr = 32'h80;
    prev_if = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic exp_if;
      exp_if = (k % 2 == 0);
      @(negedge clk);
      n_checks++; if (bus.if_ready !== exp_if || bus.d_ready !== !exp_if) begin n_fail++; $display("FAIL cont_grant[%0d]: got if=%b d=%b expected %b %b", k, bus.if_ready, bus.d_ready, exp_if, !exp_if); end
      n_checks++; if (bus.mem_addr !== (exp_if ? 11'd16 : 11'd32)) begin n_fail++; $display("FAIL cont_addr[%0d]: got %0d expected %0d", k, bus.mem_addr, exp_if ? 16 : 32); end
      if (k > 0) begin
        n_checks++; if (bus.if_valid !== prev_if || bus.d_valid !== !prev_if) begin n_fail++; $display("FAIL cont_valid[%0d]: got if=%b d=%b expected %b %b", k, bus.if_valid, bus.d_valid, prev_if, !prev_if); end
      end
      prev_if = exp_if;
      step();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b1) begin n_fail++; $display("FAIL cont_last_valid: got if=%b d=%b expected 0 1", bus.if_valid, bus.d_valid); end
    n_checks++; if (rr_last_dbg !== 1'b1) begin n_fail++; $display("FAIL cont_rr: got %b expected 1", rr_last_dbg); end
    step();
  endtask

  task automatic test_store_load();
    step(); bus.d_req = 1'b1; bus.d_wren = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (bus.d_ready !== 1'b1 || bus.mem_wren !== 1'b1) begin n_fail++; $display("FAIL st_grant: got ready=%b wren=%b expected 1 1", bus.d_ready, bus.mem_wren); end
    n_checks++; if (bus.mem_addr !== 11'd8 || bus.mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_mem: got addr=%0d wdata=%h expected 8 deadbeef", bus.mem_addr, bus.mem_wdata); end
    step(); bus.d_wren = 1'b0; bus.d_wdata = '0;
    @(negedge clk);
    n_checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== '0 || state_dbg !== 2'd3) begin n_fail++; $display("FAIL st_ack: got valid=%b data=%h state=%0d expected 1 0 3", bus.d_valid, bus.d_rdata, state_dbg); end
    n_checks++; if (bus.d_ready !== 1'b1 || bus.mem_wren !== 1'b0) begin n_fail++; $display("FAIL ld_grant: got ready=%b wren=%b expected 1 0", bus.d_ready, bus.mem_wren); end
    step(); idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_data: got valid=%b data=%h expected 1 deadbeef", bus.d_valid, bus.d_rdata); end
    n_checks++; if (bus.mem_wdata !== '0) begin n_fail++; $display("FAIL idle_wdata: got %h expected 0", bus.mem_wdata); end
    step();
  endtask

  task automatic test_flash();
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h14;
    @(negedge clk);
    n_checks++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL fl_pre_grant: got %b expected 1", bus.if_ready); end
    step(); flash_en = 1'b1; bus.d_req = 1'b1; bus.d_wren = 1'b1; bus.d_addr = 32'h44; bus.d_wdata = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (bus.if_ready !== 1'b0 || bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready[%0d]: got if=%b d=%b expected 0 0", c, bus.if_ready, bus.d_ready); end
      n_checks++; if (bus.mem_wren !== 1'b0 || bus.mem_wdata !== '0 || bus.mem_addr !== 11'd5) begin n_fail++; $display("FAIL fl_mem[%0d]: got wren=%b wdata=%h addr=%0d expected 0 0 5", c, bus.mem_wren, bus.mem_wdata, bus.mem_addr); end
      if (c == 0) begin
        n_checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== init_word(5)) begin n_fail++; $display("FAIL fl_inflight: got valid=%b data=%h expected 1 %h", bus.if_valid, bus.if_rdata, init_word(5)); end
      end else begin
        n_checks++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fl_quiet[%0d]: got if=%b d=%b busy=%b expected 0 0 0", c, bus.if_valid, bus.d_valid, busy); end
      end
      step();
    end
    flash_en = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.if_ready !== 1'b1 || bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL fl_resume: got if=%b d=%b expected 1 0", bus.if_ready, bus.d_ready); end
    step(); idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.d_req = 1'b1; bus.d_wren = 1'b0; bus.d_addr = 32'h30;
    @(negedge clk);
    n_checks++; if (bus.d_ready !== 1'b1) begin n_fail++; $display("FAIL rm_grant: got %b expected 1", bus.d_ready); end
    step(); idle_inputs(); rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.d_valid !== 1'b0 || busy !== 1'b0 || bus.d_rdata !== '0) begin n_fail++; $display("FAIL rm_drop: got valid=%b busy=%b data=%h expected 0 0 0", bus.d_valid, busy, bus.d_rdata); end
    #2 exp_d_q.delete();
    step(); rst = 1'b0;
    @(negedge clk);
    n_checks++; if (state_dbg !== 2'd0 || busy !== 1'b0 || bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL rm_idle: got state=%0d busy=%b valid=%b expected 0 0 0", state_dbg, busy, bus.d_valid); end
  endtask

  task automatic test_misaligned();
    step(); bus.d_req = 1'b1; bus.d_wren = 1'b0; bus.d_addr = 32'h23;
    @(negedge clk);
    n_checks++; if (bus.d_ready !== 1'b1 || bus.mem_addr !== 11'd8) begin n_fail++; $display("FAIL mis_addr: got ready=%b addr=%0d expected 1 8", bus.d_ready, bus.mem_addr); end
    step(); bus.d_addr = 32'hFFFF_E023;
    @(negedge clk);
    n_checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mis_data: got valid=%b data=%h expected 1 deadbeef", bus.d_valid, bus.d_rdata); end
    n_checks++; if (bus.mem_addr !== 11'd8) begin n_fail++; $display("FAIL hi_addr: got %0d expected 8", bus.mem_addr); end
    step(); idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hi_data: got %h expected deadbeef", bus.d_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    logic rr_d, if_hold, d_hold, exp_gi, exp_gd;
    do_reset();
    rr_d = 1'b1; if_hold = 1'b0; d_hold = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!if_hold) begin
        bus.if_req = 1'($urandom_range(0, 1));
        bus.if_addr = 32'($urandom_range(0, 63));
      end
      if (!d_hold) begin
        bus.d_req = 1'($urandom_range(0, 1));
        bus.d_wren = 1'($urandom_range(0, 1));
        bus.d_addr = 32'($urandom_range(0, 63));
        bus.d_wdata = $urandom;
      end
      flash_en = ($urandom_range(0, 9) == 0);
      exp_gi = 1'b0; exp_gd = 1'b0;
      if (!flash_en) begin
        if (bus.if_req && bus.d_req) begin exp_gi = rr_d; exp_gd = !rr_d; end
        else begin exp_gi = bus.if_req; exp_gd = bus.d_req; end
      end
      @(negedge clk);
      n_checks++; if (bus.if_ready !== exp_gi || bus.d_ready !== exp_gd) begin n_fail++; $display("FAIL b2b_grant[%0d]: got if=%b d=%b expected %b %b", n, bus.if_ready, bus.d_ready, exp_gi, exp_gd); end
      n_checks++; if (bus.mem_wren !== (exp_gd && bus.d_wren)) begin n_fail++; $display("FAIL b2b_wren[%0d]: got %b expected %b", n, bus.mem_wren, exp_gd && bus.d_wren); end
      if (exp_gi || exp_gd) begin
        n_checks++; if (bus.mem_addr !== (exp_gi ? word_of(bus.if_addr) : word_of(bus.d_addr))) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", n, bus.mem_addr, exp_gi ? word_of(bus.if_addr) : word_of(bus.d_addr)); end
      end
      if (!flash_en && bus.if_req && bus.d_req) rr_d = exp_gd;
      if_hold = bus.if_req && !exp_gi;
      d_hold  = bus.d_req && !exp_gd;
      step();
    end
    idle_inputs(); flash_en = 1'b0;
    step(); step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    bus.mem_q = '0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_contention();
    test_store_load();
    test_flash();
    test_reset_mid();
    test_misaligned();
    test_back_to_back();
    @(negedge clk);
    n_checks++;
    if (exp_if_q.size() != 0 || exp_d_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got if=%0d d=%0d outstanding expected 0 0", exp_if_q.size(), exp_d_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
